dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (32-bit words, 4-bit byte write-enable, negedge write, combinational read) between two requesters: the pipeline MEM stage (cpu) and the debug/loader port (dbg).
- Arbitrates one access per cycle with registered memory drive and registered read return.
- For cpu accesses it generates byte enables and store-lane replication from size and offset, extracts and extends load data, and flags misaligned accesses.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- DATA_WIDTH, 32, data width; fixed at 32, because the byte-lane logic assumes 4 lanes.
- STARVE_LIMIT, 4, consecutive denied dbg cycles after which dbg gets priority; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  cpu access request.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- cpu_signed  in  1  sign-extend load result (byte/half only).
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_ready  out  1  combinational grant; handshake = cpu_req & cpu_ready at posedge.
- cpu_rvalid  out  1  registered response pulse, one per accepted cpu access (loads and stores).
- cpu_rdata  out  32  extracted/extended load data; 0 for stores and faults.
- cpu_fault  out  1  valid with cpu_rvalid; misaligned or reserved-size access.
- dbg_req  in  1  debug access request.
- dbg_be  in  4  raw byte enables; 0000 = read.
- dbg_addr  in  ADDR_WIDTH  address; bits [1:0] ignored.
- dbg_wdata  in  32  raw word data.
- dbg_ready  out  1  combinational grant.
- dbg_rvalid  out  1  registered response pulse.
- dbg_rdata  out  32  raw memory word.
- mem_addr  out  ADDR_WIDTH  to memory addr, driven from the stage register.
- mem_data  out  32  to memory data.
- mem_we  out  4  to memory we; bit0 = bits [7:0].
- mem_q  in  32  memory read data, combinational.

Behaviour:
- Reset (rst high at posedge):
  - All of the following go to 0: stage_valid, stage_owner, starve_cnt, mem_we, mem_addr, mem_data, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, cpu_fault.
  - An access held in the stage register is dropped: no write occurs in the following cycle and no rvalid is produced.
  - A handshake coinciding with rst is not accepted.
- Arbitration (combinational, never stalls on memory, so throughput is 1 access/cycle):
  - Only one requester active: that requester is granted.
  - Both requesting: cpu wins unless starve_cnt == STARVE_LIMIT, in which case dbg wins.
  - Both ready outputs are 0 while rst is high.
- starve_cnt:
  - Increments at posedge when dbg_req=1 and dbg_ready=0, saturating at STARVE_LIMIT.
  - Clears when dbg is granted or dbg_req=0.
- Stage (cycle A, which follows the accepting posedge):
  - mem_addr, mem_data and mem_we are driven from registers.
  - The memory writes at the negedge inside A.
  - At the posedge ending A, mem_q is captured into the owner's rdata and the owner's rvalid is 1 for exactly one cycle.
  - Load latency is 2 posedges from handshake to rvalid visible.
- Idle stage: mem_we = 0000; mem_addr and mem_data hold their last values.
- cpu byte-lane rules (off = cpu_addr[1:0], little-endian lanes):
  - Byte store: mem_we = 0001 << off; mem_data = {4{wdata[7:0]}}.
  - Half store: off 0 gives 0011, off 2 gives 1100; mem_data = {2{wdata[15:0]}}.
  - Word store: 1111 and wdata unchanged.
  - Loads: mem_we = 0000. Byte load returns lane off; half load returns lanes {off+1, off}. Either is zero- or sign-extended per cpu_signed. Word load is returned unchanged.
- cpu fault:
  - Triggers: half with off[0]=1, word with off != 0, or size 11.
  - The access is still accepted and consumes its stage slot.
  - mem_we = 0000, so memory is untouched.
  - Response: cpu_rvalid=1, cpu_fault=1, cpu_rdata=0.
- dbg: mem_addr = {dbg_addr[ADDR_WIDTH-1:2], 2'b00}, mem_we = dbg_be, and data is passed through unchanged.
- Back-to-back: a store in cycle A followed by a load of the same word in A+1 returns the new data, because the write completes at the negedge of A.

Test Plan:
- Word store then load: cpu stores 0xDEADBEEF at 0x100, then loads 0x100 → mem_we=1111 in the store's A cycle; load rvalid with rdata=0xDEADBEEF, fault=0.
- Byte lanes: store byte 0x80 at 0x101, then signed byte load at 0x101 → mem_we=0010, mem_data=0x80808080; load returns 0xFFFFFF80; unsigned load returns 0x00000080.
- Misalign: half store at 0x103 → accepted, mem_we=0000, cpu_rvalid=1, cpu_fault=1, rdata=0; word at 0x103 is unchanged.
- Starvation (STARVE_LIMIT=4): cpu_req and dbg_req held high continuously → cpu granted 4 cycles, then dbg 1 cycle, repeating 4:1. Exactly one rvalid per grant, in order.
- Debug raw access: dbg_be=1100, addr 0x203, data 0x12345678 on a word holding 0 → word 0x200 becomes 0x12340000. A dbg read of 0x200 returns it with dbg_rvalid one cycle after A.
- Reset mid-operation: rst asserted at the posedge right after a store handshake → no write (word unchanged), no rvalid, all outputs 0, starve_cnt 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between the pipeline MEM stage (cpu) and a debug/loader
// port (dbg): one access per cycle, registered memory drive, registered read return.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_signed,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_fault,

  input  logic                  dbg_req,
  input  logic [3:0]            dbg_be,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ready,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [3:0]            mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [3:0] StarveMax = STARVE_LIMIT[3:0];

  // Arbitration
  logic [3:0] starve_q, starve_d;
  logic       starve_max;
  logic       dbg_win;
  logic       cpu_hs, dbg_hs;

  assign starve_max = (starve_q == StarveMax);
  assign dbg_win    = dbg_req & (~cpu_req | starve_max);
  assign dbg_ready  = ~rst & dbg_win;
  assign cpu_ready  = ~rst & cpu_req & ~dbg_win;
  assign cpu_hs     = cpu_req & cpu_ready;
  assign dbg_hs     = dbg_req & dbg_ready;

  always_comb begin
    starve_d = 4'd0;
    if (dbg_req && !dbg_ready) begin
      starve_d = starve_max ? starve_q : starve_q + 4'd1;
    end
  end

  // cpu byte-lane decode
  logic [1:0]            cpu_off;
  logic [3:0]            cpu_be;
  logic [3:0]            cpu_be_eff;
  logic [DATA_WIDTH-1:0] cpu_wdata_rep;
  logic                  cpu_misalign;

  assign cpu_off = cpu_addr[1:0];

  always_comb begin
    cpu_be        = 4'b0000;
    cpu_wdata_rep = cpu_wdata;
    cpu_misalign  = 1'b0;
    case (cpu_size)
      2'b00: begin
        cpu_be        = 4'b0001 << cpu_off;
        cpu_wdata_rep = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        cpu_be        = cpu_off[1] ? 4'b1100 : 4'b0011;
        cpu_wdata_rep = {2{cpu_wdata[15:0]}};
        cpu_misalign  = cpu_off[0];
      end
      2'b10: begin
        cpu_be       = 4'b1111;
        cpu_misalign = (cpu_off != 2'b00);
      end
      default: cpu_misalign = 1'b1;
    endcase
  end

  assign cpu_be_eff = (cpu_we && !cpu_misalign) ? cpu_be : 4'b0000;

  // Stage register (cycle A)
  logic                  stage_valid_q;
  logic                  stage_owner_q;  // 1 = dbg
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic [3:0]            mem_we_q;
  logic [1:0]            ld_size_q;
  logic                  ld_signed_q;
  logic [1:0]            ld_off_q;
  logic                  ld_zero_q;
  logic                  ld_fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q      <= 4'd0;
      stage_valid_q <= 1'b0;
      stage_owner_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_we_q      <= 4'b0000;
      ld_size_q     <= 2'b00;
      ld_signed_q   <= 1'b0;
      ld_off_q      <= 2'b00;
      ld_zero_q     <= 1'b0;
      ld_fault_q    <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      stage_valid_q <= cpu_hs | dbg_hs;
      if (cpu_hs) begin
        stage_owner_q <= 1'b0;
        mem_addr_q    <= cpu_addr;
        mem_data_q    <= cpu_wdata_rep;
        mem_we_q      <= cpu_be_eff;
        ld_size_q     <= cpu_size;
        ld_signed_q   <= cpu_signed;
        ld_off_q      <= cpu_off;
        ld_zero_q     <= cpu_we | cpu_misalign;
        ld_fault_q    <= cpu_misalign;
      end else if (dbg_hs) begin
        stage_owner_q <= 1'b1;
        mem_addr_q    <= {dbg_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_data_q    <= dbg_wdata;
        mem_we_q      <= dbg_be;
        ld_zero_q     <= 1'b0;
        ld_fault_q    <= 1'b0;
      end else begin
        mem_we_q <= 4'b0000;
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  // Gate with rst so an access caught by reset never writes at the following negedge.
  assign mem_we   = mem_we_q & {4{~rst}};

  // Load extraction
  logic [DATA_WIDTH-1:0] ld_shifted;
  logic [DATA_WIDTH-1:0] ld_ext;

  assign ld_shifted = mem_q >> {ld_off_q, 3'b000};

  always_comb begin
    ld_ext = mem_q;
    case (ld_size_q)
      2'b00:   ld_ext = {{24{ld_signed_q & ld_shifted[7]}}, ld_shifted[7:0]};
      2'b01:   ld_ext = {{16{ld_signed_q & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_ext = mem_q;
    endcase
    if (ld_zero_q) begin
      ld_ext = '0;
    end
  end

  // Response registers
  logic                  cpu_rvalid_q, dbg_rvalid_q, cpu_fault_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, dbg_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_fault_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= stage_valid_q & ~stage_owner_q;
      dbg_rvalid_q <= stage_valid_q & stage_owner_q;
      cpu_fault_q  <= stage_valid_q & ~stage_owner_q & ld_fault_q;
      if (stage_valid_q && !stage_owner_q) begin
        cpu_rdata_q <= ld_ext;
      end
      if (stage_valid_q && stage_owner_q) begin
        dbg_rdata_q <= mem_q;
      end
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_fault  = cpu_fault_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

  logic unused_dbg_lsb;
  assign unused_dbg_lsb = ^dbg_addr[1:0];

endmodule
